// File: rtl/x_dl_ctrl_pkg.sv
// Shared types and constants for the delay-line capture sequencer.
// Holds the FSM encoding, the tap-count width and the packing of the result word.
package x_dl_ctrl_pkg;

    localparam int N_TAPS_DEF  = 128;
    localparam int CNT_W       = $clog2(N_TAPS_DEF + 1);
    localparam int RES_W       = 32;
    localparam int RES_CNT_W   = 8;
    localparam int RES_SUM_W   = 16;
    localparam int RES_MIN_LSB = 0;
    localparam int RES_MAX_LSB = 8;
    localparam int RES_SUM_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ENCODE  = 3'd4,
        ST_RELEASE = 3'd5,
        ST_DONE    = 3'd6
    } dl_state_e;

    function automatic logic [RES_W-1:0] pack_result(
        input logic [RES_SUM_W-1:0] sum_cnt,
        input logic [RES_CNT_W-1:0] max_cnt,
        input logic [RES_CNT_W-1:0] min_cnt
    );
        logic [RES_W-1:0] r;
        r = '0;
        r[RES_MIN_LSB +: RES_CNT_W] = min_cnt;
        r[RES_MAX_LSB +: RES_CNT_W] = max_cnt;
        r[RES_SUM_LSB +: RES_SUM_W] = sum_cnt;
        return r;
    endfunction

endpackage

// File: rtl/x_dl_capture_ctrl_if.sv
// Control/status bundle between the host-side control words and the capture sequencer.
// The master drives start and configuration; the slave (sequencer) reports status and result.
interface x_dl_capture_ctrl_if #(
    parameter int WAIT_W = 8,
    parameter int SMP_W  = 8
);
    import x_dl_ctrl_pkg::*;

    logic              start;
    logic [WAIT_W-1:0] cfg_wait;
    logic [SMP_W-1:0]  cfg_samples;
    logic              busy;
    logic              done;
    logic [RES_W-1:0]  result;

    modport master (
        output start, cfg_wait, cfg_samples,
        input  busy, done, result
    );

    modport slave (
        input  start, cfg_wait, cfg_samples,
        output busy, done, result
    );

endinterface

// File: rtl/x_dl_popcount.sv
// Registered popcount of the captured tap vector, built as a balanced binary adder tree.
// Output count and valid appear one clock after the data/valid inputs.
module x_dl_popcount #(
    parameter int N_TAPS = 128,
    parameter int CNT_W  = $clog2(N_TAPS + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [N_TAPS-1:0] i_data,
    output logic              o_valid,
    output logic [CNT_W-1:0]  o_count
);

    localparam int LVL = (N_TAPS > 1) ? $clog2(N_TAPS) : 0;
    localparam int P   = 1 << LVL;

    // Heap-ordered tree: node[1] is the root, leaves live at node[P..2P-1].
    logic [CNT_W-1:0] node [1:2*P-1];
    logic [CNT_W-1:0] count_reg;
    logic             valid_reg;

    genvar gi;
    generate
        for (gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < N_TAPS) begin : g_tap
                assign node[P+gi] = CNT_W'(i_data[gi]);
            end else begin : g_pad
                assign node[P+gi] = '0;
            end
        end
        for (gi = 1; gi < P; gi++) begin : g_sum
            assign node[gi] = node[2*gi] + node[2*gi+1];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            count_reg <= node[1];
            valid_reg <= i_valid;
        end
    end

    assign o_count = count_reg;
    assign o_valid = valid_reg;

endmodule

// File: rtl/x_dl_capture_ctrl.sv
// Delay-line capture sequencer: launches an edge, waits W clocks, snapshots the taps,
// popcounts them and accumulates min/max/sum over S samples into one result word.
module x_dl_capture_ctrl
    import x_dl_ctrl_pkg::*;
#(
    parameter int N_TAPS = N_TAPS_DEF,
    parameter int WAIT_W = 8,
    parameter int SMP_W  = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    x_dl_capture_ctrl_if.slave  ctrl,
    input  logic [N_TAPS-1:0]   i_dl,
    output logic                o_dl
);

    localparam int CW = $clog2(N_TAPS + 1);

    dl_state_e          state_reg;
    dl_state_e          state_next;
    logic [WAIT_W-1:0]  wait_reg;
    logic [SMP_W-1:0]   smp_reg;
    logic [WAIT_W-1:0]  timer_reg;
    logic [SMP_W-1:0]   smp_cnt_reg;
    logic [N_TAPS-1:0]  snap_reg;
    logic [CW-1:0]      min_reg;
    logic [CW-1:0]      max_reg;
    logic [RES_SUM_W-1:0] sum_reg;
    logic [RES_W-1:0]   result_reg;
    logic               dl_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               pc_valid;
    logic [CW-1:0]      pc_count;

    x_dl_popcount #(
        .N_TAPS (N_TAPS),
        .CNT_W  (CW)
    ) u_popcount (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (state_reg == ST_ENCODE),
        .i_data  (snap_reg),
        .o_valid (pc_valid),
        .o_count (pc_count)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (ctrl.start) state_next = ST_LAUNCH;
            ST_LAUNCH:  state_next = (wait_reg == '0) ? ST_CAPTURE : ST_WAIT;
            ST_WAIT:    if (timer_reg == '0) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_ENCODE;
            ST_ENCODE:  state_next = ST_RELEASE;
            ST_RELEASE: begin
                if (timer_reg == '0)
                    state_next = (smp_cnt_reg < smp_reg) ? ST_LAUNCH : ST_DONE;
            end
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            wait_reg    <= '0;
            smp_reg     <= '0;
            timer_reg   <= '0;
            smp_cnt_reg <= '0;
            snap_reg    <= '0;
            min_reg     <= '0;
            max_reg     <= '0;
            sum_reg     <= '0;
            result_reg  <= '0;
            dl_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        wait_reg    <= ctrl.cfg_wait;
                        smp_reg     <= (ctrl.cfg_samples == '0) ? SMP_W'(1) : ctrl.cfg_samples;
                        min_reg     <= '1;
                        max_reg     <= '0;
                        sum_reg     <= '0;
                        smp_cnt_reg <= '0;
                    end
                end
                // WAIT is entered with W-1 so it spans exactly W cycles.
                ST_LAUNCH:  timer_reg <= wait_reg - WAIT_W'(1);
                ST_WAIT:    if (timer_reg != '0) timer_reg <= timer_reg - WAIT_W'(1);
                ST_CAPTURE: snap_reg <= i_dl;
                ST_ENCODE: begin
                    timer_reg   <= wait_reg;
                    smp_cnt_reg <= smp_cnt_reg + SMP_W'(1);
                end
                ST_RELEASE: if (timer_reg != '0) timer_reg <= timer_reg - WAIT_W'(1);
                ST_DONE:    result_reg <= pack_result(sum_reg, RES_CNT_W'(max_reg), RES_CNT_W'(min_reg));
                default: ;
            endcase

            // The popcount lands in the first RELEASE cycle, always before DONE.
            if (pc_valid) begin
                if (pc_count < min_reg) min_reg <= pc_count;
                if (pc_count > max_reg) max_reg <= pc_count;
                sum_reg <= sum_reg + RES_SUM_W'(pc_count);
            end

            dl_reg   <= (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT) ||
                        (state_reg == ST_CAPTURE);
            busy_reg <= (state_reg != ST_IDLE);
            done_reg <= (state_reg == ST_DONE);
        end
    end

    assign o_dl        = dl_reg;
    assign ctrl.busy   = busy_reg;
    assign ctrl.done   = done_reg;
    assign ctrl.result = result_reg;

endmodule

// File: tb/tb_x_dl_capture_ctrl.sv
// Scoreboard bench for x_dl_capture_ctrl: a model delay line feeds queued tap patterns,
// expected result words and done latencies are queued at start and compared on o_done.
module tb_x_dl_capture_ctrl;
    import x_dl_ctrl_pkg::*;

    localparam int N = 128;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [N-1:0] i_dl;
    logic         o_dl;

    x_dl_capture_ctrl_if #(.WAIT_W(8), .SMP_W(8)) ctrl_if ();

    x_dl_capture_ctrl #(.N_TAPS(N), .WAIT_W(8), .SMP_W(8)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .ctrl  (ctrl_if),
        .i_dl  (i_dl),
        .o_dl  (o_dl)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] result;
        int          cycles;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] pat_q[$];
    int           cnt_q[$];
    logic [N-1:0] cur_pat = '0;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           accept_cyc = 0;
    int           done_cnt = 0;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) if (ctrl_if.done === 1'b1) done_cnt <= done_cnt + 1;

    // Model line: each launch presents the next queued tap pattern while o_dl is high.
    always @(posedge o_dl) if (pat_q.size() > 0) cur_pat = pat_q.pop_front();
    assign i_dl = o_dl ? cur_pat : '0;

    function automatic logic [N-1:0] make_pat(input int n, input bit bubbly);
        logic [N-1:0] p;
        int k;
        p = '0;
        k = 0;
        if (!bubbly) begin
            for (int i = 0; i < n; i++) p[i] = 1'b1;
        end else begin
            while (k < n) begin
                int b;
                b = int'($urandom_range(N-1, 0));
                if (!p[b]) begin
                    p[b] = 1'b1;
                    k++;
                end
            end
        end
        return p;
    endfunction

    // Model the run from cnt_q, queue patterns and expectation, optionally drive start.
    task automatic start_run(input int w, input int s, input bit bubbly, input bit hold, input bit drive);
        int   seff, mn, mx, sm;
        exp_t e;
        seff = (s == 0) ? 1 : s;
        mn = 255; mx = 0; sm = 0;
        for (int i = 0; i < seff; i++) begin
            int c;
            c = cnt_q[i];
            pat_q.push_back(make_pat(c, bubbly));
            if (c < mn) mn = c;
            if (c > mx) mx = c;
            sm += c;
        end
        cnt_q.delete();
        e.result = {sm[15:0], mx[7:0], mn[7:0]};
        e.cycles = 1 + seff * (2 * w + 4);
        exp_q.push_back(e);
        if (drive) begin
            @(negedge i_clk);
            ctrl_if.cfg_wait    = w[7:0];
            ctrl_if.cfg_samples = s[7:0];
            ctrl_if.start       = 1'b1;
            @(posedge i_clk);
            #1;
            accept_cyc = cyc;
            if (!hold) ctrl_if.start = 1'b0;
        end
    endtask

    // Bounded wait for o_done; done_rel stays -1 if the budget runs out.
    task automatic wait_done(output logic [31:0] res, output int busy_rel, output int done_rel,
                             output logic busy_after, output logic done_after);
        res = '0; busy_rel = -1; done_rel = -1; busy_after = 1'bx; done_after = 1'bx;
        for (int n = 0; n < 2000; n++) begin
            @(posedge i_clk);
            #1;
            if (busy_rel < 0 && ctrl_if.busy === 1'b1) busy_rel = cyc - accept_cyc;
            if (ctrl_if.done === 1'b1) begin
                done_rel = cyc - accept_cyc;
                res = ctrl_if.result;
                break;
            end
        end
        if (done_rel >= 0) begin
            @(posedge i_clk);
            #1;
            busy_after = ctrl_if.busy;
            done_after = ctrl_if.done;
        end
    endtask

    task automatic test_reset;
        ctrl_if.start = 1'b0; ctrl_if.cfg_wait = '0; ctrl_if.cfg_samples = '0;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        tests++; if (o_dl !== 1'b0) begin fails++; $display("FAIL reset_dl: got %b want 0", o_dl); end
        tests++; if (ctrl_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", ctrl_if.busy); end
        tests++; if (ctrl_if.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", ctrl_if.done); end
        tests++; if (ctrl_if.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", ctrl_if.result); end
        @(negedge i_clk);
        i_rst = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_single;
        logic [31:0] res; int b, d; logic ba, da; exp_t e;
        cnt_q = '{37};
        start_run(0, 1, 1'b0, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++;
        if (d < 0) begin fails++; $display("FAIL single_timeout: got no done want done"); end
        else begin
            tests++; if (res !== e.result) begin fails++; $display("FAIL single_result: got %h want %h", res, e.result); end
            tests++; if (d != e.cycles) begin fails++; $display("FAIL single_latency: got %0d want %0d", d, e.cycles); end
            tests++; if (b != 1) begin fails++; $display("FAIL single_busy_rise: got %0d want 1", b); end
            tests++; if (ba !== 1'b0 || da !== 1'b0) begin fails++; $display("FAIL single_done_width: got busy=%b done=%b want 0 0", ba, da); end
        end
        $display("[TB] single W=0 S=1 result=%h done_at=%0d", res, d);
    endtask

    task automatic test_multi;
        logic [31:0] res; int b, d; logic ba, da; exp_t e;
        cnt_q = '{10, 50, 20, 50};
        start_run(3, 4, 1'b0, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL multi_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL multi_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] multi W=3 S=4 result=%h done_at=%0d", res, d);
    endtask

    task automatic test_extremes;
        logic [31:0] res; int b, d; logic ba, da; exp_t e;
        cnt_q = '{0, 128};
        start_run(2, 2, 1'b0, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL extremes_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL extremes_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] extremes W=2 S=2 result=%h done_at=%0d", res, d);
    endtask

    task automatic test_bubbles;
        logic [31:0] res; int b, d; logic ba, da; exp_t e;
        cnt_q = '{45, 77, 3};
        start_run(1, 3, 1'b1, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL bubbles_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL bubbles_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] bubbles W=1 S=3 result=%h done_at=%0d", res, d);
    endtask

    task automatic test_busy_ignore;
        logic [31:0] res; int b, d, d0; logic ba, da; exp_t e;
        d0 = done_cnt;
        cnt_q = '{33};
        start_run(5, 1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge i_clk);
        ctrl_if.start = 1'b1;
        @(negedge i_clk);
        ctrl_if.start = 1'b0;
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL ignore_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", d, e.cycles); end
        repeat (40) @(posedge i_clk);
        #1;
        tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
        tests++; if (ctrl_if.busy !== 1'b0) begin fails++; $display("FAIL ignore_idle: got busy=%b want 0", ctrl_if.busy); end
        $display("[TB] busy_ignore result=%h done_pulses=%0d", res, done_cnt - d0);

        cnt_q = '{60};
        start_run(1, 0, 1'b0, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL s0_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL s0_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] samples_zero W=1 result=%h done_at=%0d", res, d);
    endtask

    task automatic test_reset_midrun;
        logic [31:0] res; int b, d, d0; logic ba, da; exp_t e;
        cnt_q = '{4, 5, 6, 7};
        start_run(2, 4, 1'b0, 1'b0, 1'b1);
        // Sample 2 occupies edges +8..+15 after acceptance; RELEASE starts at +13.
        repeat (13) @(posedge i_clk);
        #2;
        d0 = done_cnt;
        i_rst = 1'b1;
        #1;
        tests++; if (o_dl !== 1'b0) begin fails++; $display("FAIL midrst_dl: got %b want 0", o_dl); end
        tests++; if (ctrl_if.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", ctrl_if.busy); end
        tests++; if (ctrl_if.result !== 32'h0) begin fails++; $display("FAIL midrst_result: got %h want 0", ctrl_if.result); end
        void'(exp_q.pop_front());
        pat_q.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (40) @(posedge i_clk);
        #1;
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
        $display("[TB] reset_midrun busy=%b result=%h", ctrl_if.busy, ctrl_if.result);

        cnt_q = '{5, 9};
        start_run(0, 2, 1'b0, 1'b0, 1'b1);
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL postrst_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL postrst_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] post_reset run result=%h done_at=%0d", res, d);
    endtask

    task automatic test_config_latch;
        logic [31:0] res; int b, d; logic ba, da; exp_t e;
        cnt_q = '{1, 2, 3};
        start_run(2, 3, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge i_clk);
        ctrl_if.cfg_wait    = 8'd9;
        ctrl_if.cfg_samples = 8'd1;
        wait_done(res, b, d, ba, da);
        e = exp_q.pop_front();
        tests++; if (res !== e.result) begin fails++; $display("FAIL latch_result: got %h want %h", res, e.result); end
        tests++; if (d != e.cycles) begin fails++; $display("FAIL latch_latency: got %0d want %0d", d, e.cycles); end
        $display("[TB] config_latch result=%h done_at=%0d", res, d);
    endtask

    task automatic test_back_to_back;
        logic [31:0] res1, res2; int b, d1, d2; logic ba, da; exp_t e1, e2;
        cnt_q = '{7};
        start_run(0, 1, 1'b0, 1'b1, 1'b1);
        cnt_q = '{11};
        start_run(0, 1, 1'b0, 1'b0, 1'b0);
        wait_done(res1, b, d1, ba, da);
        // Start held: DONE (1) plus one IDLE cycle, so the next accept is 6 edges later.
        accept_cyc = accept_cyc + 6;
        tests++; if (ba !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got busy=%b want 0", ba); end
        @(negedge i_clk);
        ctrl_if.start = 1'b0;
        wait_done(res2, b, d2, ba, da);
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        tests++; if (res1 !== e1.result) begin fails++; $display("FAIL b2b_result1: got %h want %h", res1, e1.result); end
        tests++; if (res2 !== e2.result) begin fails++; $display("FAIL b2b_result2: got %h want %h", res2, e2.result); end
        tests++; if (d2 != e2.cycles) begin fails++; $display("FAIL b2b_latency2: got %0d want %0d", d2, e2.cycles); end
        $display("[TB] back_to_back result1=%h result2=%h done2_at=%0d", res1, res2, d2);
    endtask

    initial begin
        ctrl_if.start = 1'b0;
        ctrl_if.cfg_wait = '0;
        ctrl_if.cfg_samples = '0;
        test_reset();
        test_single();
        test_multi();
        test_extremes();
        test_bubbles();
        test_busy_ignore();
        test_reset_midrun();
        test_config_latch();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
